serial_chunk_adder: RTL and testbench

//  Multi-cycle parametrised adder. It adds two WIDTH-bit operands plus a carry-in,

---
 rtl/serial_chunk_adder.sv | 71 +++++++
 tb/tb_serial_chunk_adder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, LSB chunk first
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] sa, sb, work, work_d;
  logic [CW-1:0] cnt;
  logic [IW-1:0] base;
  logic [CHUNK:0] part;
  logic carry, last, accept;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign accept = start && !busy;
  assign last   = cnt == CW'(N - 1);
  always_comb begin
    base   = IW'(int'(cnt) * CHUNK);
    part   = {1'b0, sa[base +: CHUNK]} + {1'b0, sb[base +: CHUNK]} + {{CHUNK{1'b0}}, carry};
    work_d = work;
    work_d[base +: CHUNK] = part[CHUNK-1:0];
  end
  always_comb begin
    state_d = busy ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        sa    <= a;
        sb    <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (busy) begin
        work  <= work_d;
        carry <= part[CHUNK];
        cnt   <= last ? '0 : cnt + 1'b1;
        if (last) begin
          sum  <= work_d;
          cout <= part[CHUNK];
          ovf  <= (sa[WIDTH-1] == sb[WIDTH-1]) && (work_d[WIDTH-1] != sa[WIDTH-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed and back-to-back checks of serial_chunk_adder at several chunk sizes
module tb_serial_chunk_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [3:0] st, ci, bz, dn, co, ov;
  logic [3:0][7:0] a, b, s;
  logic st16, ci16, bz16, dn16, co16, ov16;
  logic [15:0] a16, b16, s16;
  int vectors = 0;
  int miscompares = 0;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_chunk_adder #(.WIDTH(8), .CHUNK(1 << g)) dut (
      .clk(clk), .rst(rst), .start(st[g]), .a(a[g]), .b(b[g]), .cin(ci[g]),
      .busy(bz[g]), .done(dn[g]), .sum(s[g]), .cout(co[g]), .ovf(ov[g]));
  end
  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .cin(ci16),
    .busy(bz16), .done(dn16), .sum(s16), .cout(co16), .ovf(ov16));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op8(input int u, input logic [7:0] av, input logic [7:0] bv, input logic c,
                     input logic hold, input logic [7:0] es, input logic ec, input logic eo);
    int k;
    @(negedge clk);
    a[u] = av; b[u] = bv; ci[u] = c; st[u] = 1'b1;
    @(posedge clk); #1;
    if (!hold) st[u] = 1'b0;
    chk("busy_after_accept", bz[u], 1);
    k = 1;
    while (!dn[u] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency_edges", k, (8 >> u) + 1);
    chk("sum", s[u], es);
    chk("cout", co[u], ec);
    chk("ovf", ov[u], eo);
  endtask
  initial begin
    int k, n;
    logic [7:0] av, bv;
    logic c;
    logic [8:0] r;
    rst = 1'b1; st = '0; ci = '0; a = '0; b = '0;
    st16 = 1'b0; ci16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bz[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_sum", s[0], 0);
    chk("rst_sum16", s16, 0);
    chk("rst_cout16", co16, 0);
    @(negedge clk);
    rst = 1'b0;
    op8(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("done_one_cycle", dn[0], 0);
    chk("sum_held_idle", s[0], 8'h00);
    op8(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'hEDCB; ci16 = 1'b1; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    k = 1;
    while (!dn16 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency16", k, 5);
    chk("sum16", s16, 16'h0000);
    chk("cout16", co16, 1);
    chk("ovf16", ov16, 0);
    @(negedge clk);
    a[0] = 8'h12; b[0] = 8'h34; ci[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      st[0] = (i < 7) && (i % 3 == 0);
      a[0] = st[0] ? 8'h55 : 8'($urandom);
      b[0] = 8'($urandom);
      ci[0] = 1'($urandom);
      @(posedge clk); #1;
      if (dn[0]) n++;
      if (i < 6) chk("sum_held_run", s[0], 8'h00);
    end
    chk("ignore_start_pulses", n, 1);
    chk("ignore_start_sum", s[0], 8'h46);
    chk("ignore_start_cout", co[0], 0);
    op8(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    a[0] = 8'h0F; b[0] = 8'h01; ci[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", bz[0], 0);
    chk("abort_done", dn[0], 0);
    chk("abort_sum", s[0], 0);
    chk("abort_cout", co[0], 0);
    chk("abort_ovf", ov[0], 0);
    op8(0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    for (int u = 0; u < 4; u++) begin
      for (int i = 0; i < 256; i++) begin
        av = 8'($urandom);
        bv = 8'($urandom);
        c = 1'($urandom_range(0, 1));
        r = {1'b0, av} + {1'b0, bv} + {8'd0, c};
        op8(u, av, bv, c, 1'b1, r[7:0], r[8], (av[7] == bv[7]) && (r[7] != av[7]));
      end
      st[u] = 1'b0;
      repeat (3) @(posedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
